wb_conbus_rr: RTL and testbench
===============================

# wb_conbus_rr

Parametrised shared-bus Wishbone interconnect connecting NM masters (CPU instruction bus, CPU data bus, JTAG bridge, DMA-capable peripherals) to NS address-decoded slaves (RAM, debug monitor, Ethernet buffers, CSR bridge). Master and slave counts, decode width and slave base addresses are parameters. Arbitration is fair round-robin with grant held for a whole cycle (CYC) burst. Unmapped accesses terminate with a bus error, and an optional watchdog terminates stalled slaves.

## Interface
- NM, 4: number of masters, 1..8.
- NS, 6: number of slaves, 1..8.
- DEC_W, 3: number of address MSBs decoded, 1..8.
- S_ADDR, {NS{DEC_W'b0}}: flattened slave base patterns; slave s matches when adr[31:32-DEC_W] == S_ADDR[s*DEC_W +: DEC_W].
- TIMEOUT, 1024: watchdog limit in cycles, 2..65535 (used only with WB_CONBUS_TIMEOUT_EN).
- sys_clk  in  1  system clock; all logic on rising edge.
- sys_rst  in  1  asynchronous, active-high reset.
- m_adr_i / m_dat_i  in  32*NM each  master address / write data, master m at [m*32 +: 32].
- m_sel_i  in  4*NM  byte selects.  m_cti_i  in  3*NM  cycle type.
- m_we_i, m_cyc_i, m_stb_i  in  NM each  per-master control.
- m_dat_o  out  32  read data, broadcast to all masters.
- m_ack_o, m_err_o  out  NM each  per-master termination.
- s_adr_o, s_dat_o, s_sel_o, s_cti_o, s_we_o  out  32/32/4/3/1  granted master's signals, broadcast to all slaves.
- s_cyc_o, s_stb_o  out  NS each  per-slave cycle/strobe.
- s_dat_i  in  32*NS  slave read data.  s_ack_i  in  NS  slave acknowledge.

## Operation
- State: grant_vld (1 bit), grant (clog2(NM) bits), last (clog2(NM) bits). Reset: grant_vld=0, grant=0, last=NM-1, so master 0 wins the first tie.
- Arbitration, evaluated every cycle when grant_vld=0 or the granted master's cyc is low:
  - Search masters last+1, last+2, … mod NM. The first one with cyc=1 becomes grant, and last and grant_vld are set accordingly.
  - If no master requests, grant_vld goes to 0.
- A granted master keeps the bus for as long as its cyc stays high, across any number of stb transfers. There is no preemption.
- A granted master that drops cyc in the same cycle another master requests: the next master takes the grant at that same edge. No idle cycle is inserted.
- Decode is combinational on the granted m_adr. The lowest-index matching slave wins.
  - s_cyc_o[s] = grant_vld & m_cyc[grant] & match[s].
  - s_stb_o[s] = the same terms with m_stb[grant].
  - All non-selected slave cyc and stb are 0.
- Return path: m_ack_o[grant] = s_ack_i[sel], and m_dat_o = s_dat_i[sel]. Every non-granted master has ack=0 and err=0.
- Unmapped address: no slave is strobed. A registered error flag raises m_err_o[grant] one cycle after stb and holds it for exactly 1 cycle, then clears; the master may then issue its next access.
- If s_ack_i arrives for a slave that is not selected, it is ignored.

## Timing
- Bus grant latency: master raises cyc/stb in cycle 0 on an idle bus, takes grant at edge 1, and the slave sees stb from cycle 1. A slave that acks combinationally in cycle 1 completes the access in 2 cycles.
- Once granted, the data path is purely combinational: zero added latency per beat. Burst throughput is 1 beat per cycle if the slave sustains it.
- Unmapped error: asserted in cycle n+1 for stb in cycle n.
- Output values while sys_rst is high:
  - s_cyc_o=0, s_stb_o=0, m_ack_o=0, m_err_o=0.
  - Broadcast buses follow master 0's inputs.
  - m_dat_o = s_dat_i[0].
- Reset asserted mid-transfer: all outputs idle immediately (asynchronous), and any in-flight access is abandoned.

## Configuration
- WB_CONBUS_TIMEOUT_EN defined:
  - A 16-bit counter clears whenever the granted master has stb low, or on any ack/err.
  - Otherwise it increments.
  - On reaching TIMEOUT-1 it pulses m_err_o[grant] for 1 cycle, forces s_stb_o low for that cycle, and clears.
  - Counter resets to 0.
- Undefined: no counter. A slave that never acks stalls its master indefinitely while holding the grant.

## Test plan
- Single master 0 reads 0x00000010 from slave 0 (S_ADDR=000), slave acks in cycle 1 with 0xDEADBEEF -> m_ack_o[0]=1 at cycle 1, m_dat_o=0xDEADBEEF, s_stb_o=6'b000001.
- Masters 0,1,2 assert cyc in the same cycle with single accesses, then each drops cyc after its ack -> grant order 0,1,2, then 0 again. No idle cycle between handoffs.
- Master 1 holds cyc across a 4-beat CTI=010 burst while master 0 requests -> master 0 gets no ack until master 1 drops cyc, then is granted at that same edge.
- Access to 0x40000000 with slave 2 address pattern unmapped (NS=2, slaves at 000/001) -> no s_stb_o asserted, m_err_o pulses exactly 1 cycle after stb.
- With WB_CONBUS_TIMEOUT_EN and TIMEOUT=16, slave never acks -> m_err_o pulses 16 cycles after grant, then the master's next access is served normally.
- sys_rst asserted mid-burst -> s_cyc_o, s_stb_o, m_ack_o go 0 without waiting for a clock edge. After release, master 0 wins a tie against master 3.

Source files
------------

// File: rtl/wb_conbus_rr_if.sv
// wb_conbus_rr_if: bundled signals of the shared-bus Wishbone interconnect.
//
// Parameters: NM masters, NS slaves (must match the wb_conbus_rr instance).
// Master-side fields (m_*) are packed per master at [m*W +: W]; slave read data
// is packed per slave at [s*32 +: 32].
//
// Modports:
//   slave  - the interconnect itself: it is the slave of the masters' requests.
//            It takes m_* requests and s_dat_i/s_ack_i, and drives everything else.
//   master - the environment (masters plus slave devices) driving the interconnect.
interface wb_conbus_rr_if #(
    parameter int unsigned NM = 4,
    parameter int unsigned NS = 6
) ();
    // Master side
    logic [32*NM-1:0] m_adr_i;
    logic [32*NM-1:0] m_dat_i;
    logic [4*NM-1:0]  m_sel_i;
    logic [3*NM-1:0]  m_cti_i;
    logic [NM-1:0]    m_we_i;
    logic [NM-1:0]    m_cyc_i;
    logic [NM-1:0]    m_stb_i;
    logic [31:0]      m_dat_o;
    logic [NM-1:0]    m_ack_o;
    logic [NM-1:0]    m_err_o;
    // Slave side
    logic [31:0]      s_adr_o;
    logic [31:0]      s_dat_o;
    logic [3:0]       s_sel_o;
    logic [2:0]       s_cti_o;
    logic             s_we_o;
    logic [NS-1:0]    s_cyc_o;
    logic [NS-1:0]    s_stb_o;
    logic [32*NS-1:0] s_dat_i;
    logic [NS-1:0]    s_ack_i;

    modport slave (
        input  m_adr_i, m_dat_i, m_sel_i, m_cti_i, m_we_i, m_cyc_i, m_stb_i,
        input  s_dat_i, s_ack_i,
        output m_dat_o, m_ack_o, m_err_o,
        output s_adr_o, s_dat_o, s_sel_o, s_cti_o, s_we_o, s_cyc_o, s_stb_o
    );

    modport master (
        output m_adr_i, m_dat_i, m_sel_i, m_cti_i, m_we_i, m_cyc_i, m_stb_i,
        output s_dat_i, s_ack_i,
        input  m_dat_o, m_ack_o, m_err_o,
        input  s_adr_o, s_dat_o, s_sel_o, s_cti_o, s_we_o, s_cyc_o, s_stb_o
    );
endinterface

// File: rtl/wb_conbus_rr.sv
// wb_conbus_rr: shared-bus Wishbone interconnect, NM masters to NS slaves.
//
// Round-robin arbitration; the grant is held for the whole CYC burst. The granted
// master's address MSBs (DEC_W bits) select the lowest-index matching slave.
// Unmapped accesses get a one-cycle registered bus error.
//
// Ports:
//   sys_clk - system clock, rising edge
//   sys_rst - asynchronous active-high reset
//   bus     - wb_conbus_rr_if.slave, all master and slave bus signals
//
// Optional feature: define WB_CONBUS_TIMEOUT_EN to enable a watchdog that
// errors out an access the selected slave has not acked within TIMEOUT cycles.
module wb_conbus_rr #(
    parameter int unsigned          NM      = 4,
    parameter int unsigned          NS      = 6,
    parameter int unsigned          DEC_W   = 3,
    parameter logic [NS*DEC_W-1:0]  S_ADDR  = '0,
    parameter int unsigned          TIMEOUT = 1024
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    wb_conbus_rr_if.slave   bus
);
    localparam int unsigned GW = (NM > 1) ? $clog2(NM) : 1;
    localparam int unsigned SW = (NS > 1) ? $clog2(NS) : 1;

    logic          grant_vld_q, grant_vld_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] last_q, last_d;
    logic          err_q, err_d;

    logic [31:0]   g_adr;
    logic          g_stb;
    logic          active;
    logic          hit;
    logic [SW-1:0] sel;
    logic [SW-1:0] dsel;
    logic          slave_ack;
    logic          to_fire;

    // Round-robin search starting after the last winner; only runs while the
    // bus is free, so a granted master keeps it as long as its cyc is high.
    always_comb begin
        logic          found;
        logic [GW-1:0] cand;
        grant_d     = grant_q;
        last_d      = last_q;
        grant_vld_d = grant_vld_q;
        found       = 1'b0;
        cand        = '0;
        if (!grant_vld_q || !bus.m_cyc_i[grant_q]) begin
            grant_vld_d = 1'b0;
            for (int i = 1; i <= int'(NM); i++) begin
                cand = GW'((int'(last_q) + i) % int'(NM));
                if (!found && bus.m_cyc_i[cand]) begin
                    found       = 1'b1;
                    grant_d     = cand;
                    last_d      = cand;
                    grant_vld_d = 1'b1;
                end
            end
        end
    end

    assign g_adr  = bus.m_adr_i[int'(grant_q)*32 +: 32];
    assign g_stb  = bus.m_stb_i[grant_q];
    assign active = grant_vld_q & bus.m_cyc_i[grant_q];

    // Descending scan so the lowest-index matching slave wins.
    always_comb begin
        hit = 1'b0;
        sel = '0;
        for (int s = int'(NS) - 1; s >= 0; s--) begin
            if (g_adr[31 -: DEC_W] == S_ADDR[s*DEC_W +: DEC_W]) begin
                hit = 1'b1;
                sel = SW'(s);
            end
        end
    end

    // Read data comes from slave 0 when nobody holds the grant (e.g. in reset).
    assign dsel      = grant_vld_q ? sel : '0;
    assign slave_ack = hit & bus.s_ack_i[sel];

    // Error flag for an unmapped strobe; the !err_q term limits it to one cycle.
    assign err_d = active & g_stb & ~hit & ~err_q;

`ifdef WB_CONBUS_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;

    assign to_fire = active & g_stb & ~slave_ack & (cnt_q == 16'(TIMEOUT - 1));

    always_comb begin
        if (!active || !g_stb || slave_ack || err_q || to_fire) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic [15:0] unused_timeout;
    assign unused_timeout = 16'(TIMEOUT);
    assign to_fire        = 1'b0;
`endif

    always_comb begin
        bus.s_adr_o = g_adr;
        bus.s_dat_o = bus.m_dat_i[int'(grant_q)*32 +: 32];
        bus.s_sel_o = bus.m_sel_i[int'(grant_q)*4 +: 4];
        bus.s_cti_o = bus.m_cti_i[int'(grant_q)*3 +: 3];
        bus.s_we_o  = bus.m_we_i[grant_q];
        bus.m_dat_o = bus.s_dat_i[int'(dsel)*32 +: 32];
        bus.s_cyc_o = '0;
        bus.s_stb_o = '0;
        bus.m_ack_o = '0;
        bus.m_err_o = '0;
        if (active && hit) begin
            bus.s_cyc_o[sel]     = 1'b1;
            bus.s_stb_o[sel]     = g_stb & ~to_fire;
            bus.m_ack_o[grant_q] = bus.s_ack_i[sel];
        end
        if (grant_vld_q) begin
            bus.m_err_o[grant_q] = err_q | to_fire;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            grant_vld_q <= 1'b0;
            grant_q     <= '0;
            last_q      <= GW'(NM - 1);
            err_q       <= 1'b0;
        end else begin
            grant_vld_q <= grant_vld_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            err_q       <= err_d;
        end
    end
endmodule

// File: tb/tb_wb_conbus_rr.sv
// tb_wb_conbus_rr: directed self-checking bench for wb_conbus_rr.
// Four masters, two slaves at patterns 000 and 001 (0x4xxxxxxx is unmapped).
// Slave 0 returns 0xDEADBEEF, slave 1 returns 0xCAFEF00D, acking while strobed.
module tb_wb_conbus_rr;
    localparam int unsigned NM    = 4;
    localparam int unsigned NS    = 2;
    localparam int unsigned DEC_W = 3;
    localparam int unsigned TO    = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_conbus_rr_if #(.NM(NM), .NS(NS)) bus ();

    wb_conbus_rr #(
        .NM      (NM),
        .NS      (NS),
        .DEC_W   (DEC_W),
        .S_ADDR  (6'b001_000),
        .TIMEOUT (TO)
    ) dut (
        .sys_clk (clk),
        .sys_rst (rst),
        .bus     (bus)
    );

    logic [NS-1:0] ack_en;
    logic [NS-1:0] stray_ack;

    always_comb bus.s_ack_i = (bus.s_stb_o & ack_en) | stray_ack;
    assign bus.s_dat_i = {32'hCAFEF00D, 32'hDEADBEEF};

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic set_m(input int m, input logic c, input logic s, input logic [31:0] a);
        bus.m_cyc_i[m]         = c;
        bus.m_stb_i[m]         = s;
        bus.m_adr_i[m*32 +: 32] = a;
    endtask

    task automatic idle_all();
        bus.m_adr_i = '0;
        bus.m_dat_i = '0;
        bus.m_sel_i = '1;
        bus.m_cti_i = '0;
        bus.m_we_i  = '0;
        bus.m_cyc_i = '0;
        bus.m_stb_i = '0;
        ack_en      = '1;
        stray_ack   = '0;
    endtask

    // Returns just after the edge that follows release: caller drives cycle 0.
    task automatic do_reset();
        rst = 1'b1;
        idle_all();
        repeat (2) tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_all();
        // Reset outputs: master 0 requests an address decoding to slave 1.
        set_m(0, 1'b1, 1'b1, 32'h3234_5678);
        #3;
        check_eq("rst_cyc", 32'(bus.s_cyc_o), 32'h0);
        check_eq("rst_stb", 32'(bus.s_stb_o), 32'h0);
        check_eq("rst_ack", 32'(bus.m_ack_o), 32'h0);
        check_eq("rst_err", 32'(bus.m_err_o), 32'h0);
        check_eq("rst_adr", bus.s_adr_o, 32'h3234_5678);
        check_eq("rst_dat", bus.m_dat_o, 32'hDEADBEEF);
        do_reset();

        // Single read: grant at edge 1, ack in cycle 1.
        set_m(0, 1'b1, 1'b1, 32'h0000_0010);
        mid();
        check_eq("t1_c0_stb", 32'(bus.s_stb_o), 32'h0);
        tick();
        mid();
        check_eq("t1_ack", 32'(bus.m_ack_o), 32'h1);
        check_eq("t1_dat", bus.m_dat_o, 32'hDEADBEEF);
        check_eq("t1_stb", 32'(bus.s_stb_o), 32'h1);
        tick();
        set_m(0, 1'b0, 1'b0, 32'h0);

        // Round robin among masters 0,1,2.
        do_reset();
        for (int m = 0; m < 3; m++) set_m(m, 1'b1, 1'b1, 32'h0000_0010);
        tick();
        mid();
        check_eq("rr_m0", 32'(bus.m_ack_o), 32'h1);
        tick();
        set_m(0, 1'b0, 1'b0, 32'h0);
        mid();
        check_eq("rr_hand01", 32'(bus.m_ack_o), 32'h0);
        tick();
        set_m(0, 1'b1, 1'b1, 32'h0000_0010);
        mid();
        check_eq("rr_m1", 32'(bus.m_ack_o), 32'h2);
        tick();
        set_m(1, 1'b0, 1'b0, 32'h0);
        mid();
        check_eq("rr_hand12", 32'(bus.m_ack_o), 32'h0);
        tick();
        mid();
        check_eq("rr_m2", 32'(bus.m_ack_o), 32'h4);
        tick();
        set_m(2, 1'b0, 1'b0, 32'h0);
        mid();
        tick();
        mid();
        check_eq("rr_m0_again", 32'(bus.m_ack_o), 32'h1);
        tick();
        set_m(0, 1'b0, 1'b0, 32'h0);

        // Master 1 burst holds the grant against master 0.
        do_reset();
        bus.m_cti_i[5:3] = 3'b010;
        set_m(1, 1'b1, 1'b1, 32'h0000_0020);
        tick();
        set_m(0, 1'b1, 1'b1, 32'h0000_0010);
        for (int b = 0; b < 4; b++) begin
            mid();
            check_eq($sformatf("burst_beat%0d", b), 32'(bus.m_ack_o), 32'h2);
            if (b == 0) check_eq("burst_cti", 32'(bus.s_cti_o), 32'h2);
            tick();
        end
        set_m(1, 1'b0, 1'b0, 32'h0);
        mid();
        check_eq("burst_release", 32'(bus.m_ack_o), 32'h0);
        tick();
        mid();
        check_eq("burst_m0", 32'(bus.m_ack_o), 32'h1);
        tick();
        set_m(0, 1'b0, 1'b0, 32'h0);

        // Unmapped access; a stray ack from an unselected slave is ignored.
        do_reset();
        set_m(0, 1'b1, 1'b1, 32'h4000_0000);
        tick();
        stray_ack = 2'b01;
        mid();
        check_eq("unm_stb", 32'(bus.s_stb_o), 32'h0);
        check_eq("unm_cyc", 32'(bus.s_cyc_o), 32'h0);
        check_eq("unm_stray_ack", 32'(bus.m_ack_o), 32'h0);
        check_eq("unm_err_early", 32'(bus.m_err_o), 32'h0);
        tick();
        stray_ack = '0;
        mid();
        check_eq("unm_err", 32'(bus.m_err_o), 32'h1);
        tick();
        set_m(0, 1'b1, 1'b0, 32'h4000_0000);
        mid();
        check_eq("unm_err_clear", 32'(bus.m_err_o), 32'h0);
        tick();
        set_m(0, 1'b1, 1'b1, 32'h2000_0000);
        mid();
        check_eq("next_stb", 32'(bus.s_stb_o), 32'h2);
        check_eq("next_ack", 32'(bus.m_ack_o), 32'h1);
        check_eq("next_dat", bus.m_dat_o, 32'hCAFEF00D);
        tick();
        set_m(0, 1'b0, 1'b0, 32'h0);

`ifdef WB_CONBUS_TIMEOUT_EN
        // Watchdog: slave never acks, error in the 16th granted cycle.
        do_reset();
        ack_en = '0;
        set_m(0, 1'b1, 1'b1, 32'h0000_0010);
        tick();
        for (int k = 1; k < 16; k++) begin
            mid();
            check_eq($sformatf("to_wait%0d", k), 32'(bus.m_err_o), 32'h0);
            tick();
        end
        mid();
        check_eq("to_err", 32'(bus.m_err_o), 32'h1);
        check_eq("to_stb_kill", 32'(bus.s_stb_o), 32'h0);
        tick();
        ack_en = '1;
        mid();
        check_eq("to_err_clear", 32'(bus.m_err_o), 32'h0);
        check_eq("to_next_ack", 32'(bus.m_ack_o), 32'h1);
        tick();
        set_m(0, 1'b0, 1'b0, 32'h0);
`endif

        // Asynchronous reset mid-burst, then master 0 beats master 3.
        do_reset();
        set_m(0, 1'b1, 1'b1, 32'h0000_0010);
        tick();
        tick();
        #2;
        check_eq("arst_pre_ack", 32'(bus.m_ack_o), 32'h1);
        rst = 1'b1;
        #1;
        check_eq("arst_cyc", 32'(bus.s_cyc_o), 32'h0);
        check_eq("arst_stb", 32'(bus.s_stb_o), 32'h0);
        check_eq("arst_ack", 32'(bus.m_ack_o), 32'h0);
        set_m(3, 1'b1, 1'b1, 32'h0000_0010);
        tick();
        rst = 1'b0;
        tick();
        mid();
        check_eq("tie_m0", 32'(bus.m_ack_o), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
